serial_addsub_ctrl: RTL and testbench

Bit-serial sequencer for the shared 1-bit arithmetic cells (`full_adder`, `full_sub`) of the CMOS ALU. It accepts a WIDTH-bit add or subtract request through a start/busy/done handshake. It drives one operand bit pair plus the running carry/borrow into the external cells each cycle, and assembles the WIDTH-bit result and carry/borrow flag from the cell outputs. It sits between the ALU instruction decode and the single-bit cell datapath, so one adder cell and one subtractor cell serve any operand width.

---
 rtl/serial_addsub_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_addsub_ctrl
//
// Bit-serial sequencer for the shared 1-bit full_adder / full_sub cells.
// A WIDTH-bit add or subtract is accepted with start, then processed one
// bit per cycle, LSB first. Each cycle the controller drives one operand bit
// pair plus the running carry/borrow into both cells. It shifts the selected
// cell output into the result register.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start, op, a, b    request strobe (IDLE only), 0=add / 1=sub, operands
//   busy               high while bits are processed
//   done               one-cycle completion pulse
//   result, flag       sum/difference and carry/borrow-out, held until next done
//   cell_a, cell_b     current operand bits to both cells (0 outside RUN)
//   cell_cin           running carry/borrow to both cells (0 outside RUN)
//   fa_s, fa_cout      full_adder outputs (combinational from cell_*)
//   fs_d, fs_bout      full_sub outputs (combinational from cell_*)
// ---------------------------------------------------------------------------
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             cell_a,
    output logic             cell_b,
    output logic             cell_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    input  logic             fs_d,
    input  logic             fs_bout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             op_q;
    logic             cy;
    logic [CW-1:0]    cnt;

    // Output of whichever cell the latched op selects, for the current bit.
    logic             bit_out;
    logic             cy_next;
    logic [WIDTH-1:0] r_next;

    assign bit_out = op_q ? fs_d : fa_s;
    assign cy_next = op_q ? fs_bout : fa_cout;
    assign r_next  = {bit_out, r_sh[WIDTH-1:1]};

    // busy is a registered copy of (state == RUN), so gating with it forces
    // the cell inputs to 0 in every other state.
    assign cell_a   = busy & a_sh[0];
    assign cell_b   = busy & b_sh[0];
    assign cell_cin = busy & cy;

    // NOTE: all state updates use non-blocking assignments. Every register
    // then samples the pre-edge values, so r_next and cy_next see this
    // cycle's shift registers rather than a half-updated mix.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift registers are plain flops, not a memory array,
            // so clearing them on reset is cheap. It also keeps an aborted
            // operation from leaking stale bits.
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flag   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            op_q   <= 1'b0;
            cy     <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        r_sh  <= '0;
                        op_q  <= op;
                        cy    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_next;
                    cy   <= cy_next;
                    cnt  <= cnt + CW'(1);
                    // The last bit is folded straight into result/flag, so
                    // done rises on the same edge that consumes bit WIDTH-1.
                    if (cnt == LAST_BIT) begin
                        result <= r_next;
                        flag   <= cy_next;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub_ctrl
//
// Self-checking bench for serial_addsub_ctrl (WIDTH=8). Behavioural
// full_adder / full_sub cells are attached to the cell ports.
// ---------------------------------------------------------------------------
module tb_serial_addsub_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             flag;
    logic             cell_a;
    logic             cell_b;
    logic             cell_cin;
    logic             fa_s;
    logic             fa_cout;
    logic             fs_d;
    logic             fs_bout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // 1-bit arithmetic cells.
    assign fa_s    = cell_a ^ cell_b ^ cell_cin;
    assign fa_cout = (cell_a & cell_b) | (cell_a & cell_cin) | (cell_b & cell_cin);
    assign fs_d    = cell_a ^ cell_b ^ cell_cin;
    assign fs_bout = (~cell_a & cell_b) | (~cell_a & cell_cin) | (cell_b & cell_cin);

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .flag     (flag),
        .cell_a   (cell_a),
        .cell_b   (cell_b),
        .cell_cin (cell_cin),
        .fa_s     (fa_s),
        .fa_cout  (fa_cout),
        .fs_d     (fs_d),
        .fs_bout  (fs_bout)
    );

    typedef struct {
        string            name;
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] r;
        logic             f;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {flag, result}.
    function automatic logic [WIDTH:0] ref_op(input logic o, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
        if (!o) return {1'b0, x} + {1'b0, y};
        return {(x < y), WIDTH'(x - y)};
    endfunction

    // Checks that must hold in every sampled cycle.
    task automatic check_invariants();
        check("busy_done_exclusive", 32'(busy & done), 32'd0);
        if (!busy)
            check("cells_zero_when_idle", {29'd0, cell_a, cell_b, cell_cin}, 32'd0);
    endtask

    // Issue one request and wait (bounded) for done. Inputs are scrambled
    // right after acceptance to prove they were latched.
    task automatic do_op(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output logic [WIDTH-1:0] r, output logic f,
                         output int busy_cycles, output int done_at);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = ~o; a = ~x; b = ~y;
        busy_cycles = 0;
        done_at     = -1;
        for (int n = 0; n < 20 && done_at < 0; n++) begin
            if (n > 0) @(negedge clk);
            check_invariants();
            if (busy) busy_cycles++;
            if (done) done_at = n;
        end
        r = result;
        f = flag;
    endtask

    vec_t vecs[9];

    initial begin
        logic [WIDTH-1:0] r;
        logic             f;
        logic [WIDTH:0]   exp;
        int               bc;
        int               da;
        int               done_idx[$];
        logic [WIDTH:0]   done_val[$];
        logic [WIDTH:0]   exp_q[$];
        int               seen;

        vecs[0] = '{"add_5a_33", 1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0};
        vecs[1] = '{"add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{"add_ff_ff", 1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{"sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b1};
        vecs[4] = '{"sub_20_10", 1'b1, 8'h20, 8'h10, 8'h10, 1'b0};
        vecs[5] = '{"sub_7e_7e", 1'b1, 8'h7E, 8'h7E, 8'h00, 1'b0};
        vecs[6] = '{"sub_00_01", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[7] = '{"add_80_80", 1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
        vecs[8] = '{"add_00_00", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flag",   32'(flag),   32'd0);
        check("rst_cells",  {29'd0, cell_a, cell_b, cell_cin}, 32'd0);
        rst = 1'b0;

        // ---------------- directed vector table ----------------
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, f, bc, da);
            check({vecs[i].name, "_result"},  32'(r),  32'(vecs[i].r));
            check({vecs[i].name, "_flag"},    32'(f),  32'(vecs[i].f));
            check({vecs[i].name, "_busy_cy"}, 32'(bc), 32'd8);
            check({vecs[i].name, "_done_at"}, 32'(da), 32'd8);
            @(negedge clk);
            check({vecs[i].name, "_done_1cyc"}, 32'(done),   32'd0);
            check({vecs[i].name, "_hold"},      32'(result), 32'(vecs[i].r));
        end

        // ---------------- start held high, inputs changing every cycle ----
        // Values driven before edge E_k are a=0x11+7k, b=0x22+3k, op=(k%3==1).
        // Acceptances happen at E0, E10 and E20.
        foreach (vecs[i]) ;
        exp_q.push_back(ref_op(1'b0, 8'h11, 8'h22));
        exp_q.push_back(ref_op(1'b1, 8'(8'h11 + 7 * 10), 8'(8'h22 + 3 * 10)));
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check_invariants();
                if (done) begin
                    done_idx.push_back(k - 1);
                    done_val.push_back({flag, result});
                end
            end
            start = 1'b1;
            a     = 8'(8'h11 + 7 * k);
            b     = 8'(8'h22 + 3 * k);
            op    = ((k % 3) == 1);
        end
        start = 1'b0;
        check("held_done_count", 32'(done_idx.size()), 32'd2);
        if (done_idx.size() == 2) begin
            check("held_first_done_edge", 32'(done_idx[0]), 32'd8);
            check("held_done_spacing", 32'(done_idx[1] - done_idx[0]), 32'd10);
            check("held_op0_value", 32'(done_val[0]), 32'(exp_q[0]));
            check("held_op1_value", 32'(done_val[1]), 32'(exp_q[1]));
        end
        // Drain the operation accepted at E20.
        seen = 0;
        for (int n = 0; n < 20 && seen == 0; n++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("held_drain_done", 32'(seen), 32'd1);

        // ---------------- reset mid-RUN ----------------
        do_op(1'b0, 8'h5A, 8'h33, r, f, bc, da);
        check("pre_rst_result", 32'(r), 32'h8D);
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 8'hC3; b = 8'h5A;
        @(negedge clk);                       // after E0
        start = 1'b0;
        repeat (3) @(negedge clk);            // after E3
        rst = 1'b1;
        @(negedge clk);                       // after E4 (reset edge)
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_done",   32'(done),   32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_flag",   32'(flag),   32'd0);
        check("midrst_cells",  {29'd0, cell_a, cell_b, cell_cin}, 32'd0);
        rst  = 1'b0;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        do_op(1'b1, 8'h33, 8'h5A, r, f, bc, da);
        check("post_rst_result", 32'(r), 32'hD9);
        check("post_rst_flag",   32'(f), 32'd1);
        check("post_rst_done_at", 32'(da), 32'd8);

        // ---------------- random ----------------
        for (int i = 0; i < 200; i++) begin
            logic             ro;
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ro  = 1'($urandom_range(1, 0));
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            exp = ref_op(ro, ra, rb);
            do_op(ro, ra, rb, r, f, bc, da);
            check("rand_value", 32'({f, r}), 32'(exp));
            check("rand_done_at", 32'(da), 32'd8);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
